// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request, fixed-latency response strobe.
// Optional `define MISALIGN_CHECK_EN turns misaligned word/half accesses into errors.
module mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  mode,
    output logic [31:0] memory_out,
    output logic        resp_valid,
    output logic        resp_err
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_mode;
    logic        r_err, r_load;
    logic [31:0] r_mem [DEPTH];

    logic            w_accept, w_enter_resp, w_err_in, w_sel_in;
    logic [31:0]     w_addr, w_wdata, w_word, w_bsh, w_hsh, w_ext, w_mask, w_wrep;
    logic [2:0]      w_mode;
    logic            w_err, w_load, w_store;
    logic [IdxW-1:0] w_idx;
    logic            w_unused;

    always_comb begin
        w_err_in = (memread == memwrite) || (mode > 3'd4);
`ifdef MISALIGN_CHECK_EN
        if (mode == 3'd0 && address[1:0] != 2'b00) w_err_in = 1'b1;
        if ((mode == 3'd1 || mode == 3'd2) && address[0]) w_err_in = 1'b1;
`endif
    end

    assign w_accept     = (r_state == StIdle) && req_valid;
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) || (r_state == StWait && r_cnt <= 4'd1);

    // With zero wait states the access happens on the accept edge, so use live inputs.
    assign w_sel_in = (r_state == StIdle);
    assign w_addr   = w_sel_in ? address : r_addr;
    assign w_wdata  = w_sel_in ? write_data : r_wdata;
    assign w_mode   = w_sel_in ? mode : r_mode;
    assign w_err    = w_sel_in ? w_err_in : r_err;
    assign w_load   = w_sel_in ? (memread && !w_err_in) : r_load;
    assign w_store  = !w_err && !w_load;

    assign w_idx  = w_addr[IdxW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_bsh  = w_word >> {w_addr[1:0], 3'b000};
    assign w_hsh  = w_word >> {w_addr[1], 4'b0000};

    always_comb begin
        w_ext  = '0;
        w_mask = '0;
        w_wrep = '0;
        unique case (w_mode)
            3'd0: begin
                w_ext  = w_word;
                w_mask = 32'hFFFF_FFFF;
                w_wrep = w_wdata;
            end
            3'd1, 3'd2: begin
                w_ext  = {{16{w_hsh[15] & (w_mode == 3'd1)}}, w_hsh[15:0]};
                w_mask = 32'h0000_FFFF << {w_addr[1], 4'b0000};
                w_wrep = {2{w_wdata[15:0]}};
            end
            3'd3, 3'd4: begin
                w_ext  = {{24{w_bsh[7] & (w_mode == 3'd3)}}, w_bsh[7:0]};
                w_mask = 32'h0000_00FF << {w_addr[1:0], 3'b000};
                w_wrep = {4{w_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (req_valid) w_state_next = (WAIT_CYCLES == 0) ? StResp : StWait;
            StWait: if (r_cnt <= 4'd1) w_state_next = StResp;
            StResp: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == StIdle);
        resp_valid = (r_state == StResp);
        resp_err   = (r_state == StResp) && r_err;
        memory_out = ((r_state == StResp) && !r_err) ? r_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mode  <= '0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= 4'(WAIT_CYCLES);
            r_addr  <= address;
            r_wdata <= write_data;
            r_mode  <= mode;
            r_err   <= w_err_in;
            r_load  <= memread && !w_err_in;
        end else if (r_state == StWait && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else if (w_enter_resp) begin
            if (w_store) r_mem[w_idx] <= (w_word & ~w_mask) | (w_wrep & w_mask);
            r_rdata <= w_load ? w_ext : 32'h0;
        end
    end

    assign w_unused = ^{w_addr[31:IdxW+2], w_bsh[31:8], w_hsh[31:16]};
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array reference model.
module tb_mem_responder;
    localparam int unsigned DEPTH       = 256;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, memread, memwrite;
    logic [31:0] address, write_data, memory_out;
    logic [2:0]  mode;
    logic        resp_valid, resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl_mem [DEPTH*4];

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .memread    (memread),
        .memwrite   (memwrite),
        .address    (address),
        .write_data (write_data),
        .mode       (mode),
        .memory_out (memory_out),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void mdl_clear();
        for (int i = 0; i < DEPTH * 4; i++) mdl_mem[i] = 8'h00;
    endfunction

    // Byte-addressed view of the storage; upper address bits wrap.
    function automatic void mdl_req(input logic rd, input logic wr, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [2:0] md,
                                    output logic [31:0] d, output logic e);
        int base, off;
        logic [15:0] h;
        logic [7:0]  b;
        e = (rd == wr) || (md > 3'd4);
`ifdef MISALIGN_CHECK_EN
        if (md == 3'd0 && a[1:0] != 2'b00) e = 1'b1;
        if ((md == 3'd1 || md == 3'd2) && a[0]) e = 1'b1;
`endif
        d = 32'h0;
        if (e) return;
        base = int'((a / 4) % DEPTH) * 4;
        off  = (md == 3'd1 || md == 3'd2) ? (a[1] ? 2 : 0) : int'(a[1:0]);
        if (wr) begin
            if (md == 3'd0) begin
                for (int i = 0; i < 4; i++) mdl_mem[base + i] = wd[8*i +: 8];
            end else if (md <= 3'd2) begin
                mdl_mem[base + off]     = wd[7:0];
                mdl_mem[base + off + 1] = wd[15:8];
            end else begin
                mdl_mem[base + off] = wd[7:0];
            end
        end else begin
            h = {mdl_mem[base + off + 1], mdl_mem[base + off]};
            b = mdl_mem[base + off];
            case (md)
                3'd0: d = {mdl_mem[base + 3], mdl_mem[base + 2], mdl_mem[base + 1], mdl_mem[base]};
                3'd1: d = 32'($signed(h));
                3'd2: d = {16'h0, h};
                3'd3: d = 32'($signed(b));
                default: d = {24'h0, b};
            endcase
        end
    endfunction

    // Issue one request from an idle point (#1 after an edge) and check the whole response.
    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] md, output logic [31:0] got);
        logic [31:0] exp_d;
        logic        exp_e;
        int          lat;
        bit          seen;
        mdl_req(rd, wr, a, wd, md, exp_d, exp_e);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        memread    = rd;
        memwrite   = wr;
        address    = a;
        write_data = wd;
        mode       = md;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        memread    = 1'($urandom);
        memwrite   = 1'($urandom);
        address    = $urandom;
        write_data = $urandom;
        mode       = 3'($urandom);
        lat  = 1;
        seen = 0;
        while (!seen && lat < 40) begin
            if (resp_valid) begin
                seen = 1;
            end else begin
                chk({tag, "_quiet"}, {memory_out[31:1], memory_out[0] | resp_err}, 32'h0);
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
        chk({tag, "_data"}, memory_out, exp_d);
        got = memory_out;
        @(posedge clk);
        #1;
        chk({tag, "_one_shot"}, {30'h0, resp_valid, req_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] got, a, wd;
        logic [2:0]  md;
        logic        rd, wr;
        int          k;

        reset      = 1'b0;
        req_valid  = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        address    = '0;
        write_data = '0;
        mode       = '0;
        mdl_clear();
        #3;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", {memory_out[31:2], memory_out[1] | resp_valid, memory_out[0] | resp_err},
            32'h0);
        #9 reset = 1'b1;
        @(posedge clk);
        #1;

        do_req("st_word", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, got);
        do_req("ld_word", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0, got);
        chk("ld_word_const", got, 32'hDEADBEEF);
        do_req("ld_bs", 1'b1, 1'b0, 32'h13, 32'h0, 3'd3, got);
        chk("ld_bs_const", got, 32'hFFFFFFDE);
        do_req("ld_bu", 1'b1, 1'b0, 32'h12, 32'h0, 3'd4, got);
        chk("ld_bu_const", got, 32'h000000AD);
        do_req("ld_hu", 1'b1, 1'b0, 32'h10, 32'h0, 3'd2, got);
        chk("ld_hu_const", got, 32'h0000BEEF);
        do_req("ld_hs", 1'b1, 1'b0, 32'h12, 32'h0, 3'd1, got);
        chk("ld_hs_const", got, 32'hFFFFDEAD);
        do_req("st_byte", 1'b0, 1'b1, 32'h11, 32'hAAAAAA55, 3'd3, got);
        do_req("ld_merge", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0, got);
        chk("ld_merge_const", got, 32'hDEAD55EF);
        do_req("both_rw", 1'b1, 1'b1, 32'h10, 32'h0, 3'd0, got);
        do_req("ld_unchanged", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0, got);
        do_req("bad_mode", 1'b1, 1'b0, 32'h10, 32'h0, 3'd6, got);
        do_req("neither_rw", 1'b0, 1'b0, 32'h10, 32'h0, 3'd0, got);
        do_req("misalign", 1'b1, 1'b0, 32'h12, 32'h0, 3'd0, got);
        do_req("wrap", 1'b1, 1'b0, 32'h410, 32'h0, 3'd0, got);
        chk("wrap_const", got, 32'hDEAD55EF);

        // Reset in the first wait cycle must drop the store and the response.
        req_valid  = 1'b1;
        memread    = 1'b0;
        memwrite   = 1'b1;
        address    = 32'h20;
        write_data = 32'h12345678;
        mode       = 3'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        mdl_clear();
        do_req("abort_ld", 1'b1, 1'b0, 32'h20, 32'h0, 3'd0, got);
        chk("abort_ld_const", got, 32'h0);
        do_req("cleared_ld", 1'b1, 1'b0, 32'h10, 32'h0, 3'd0, got);

        for (int n = 0; n < 150; n++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wd = $urandom;
            md = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            k  = $urandom_range(0, 9);
            if (k == 0) begin
                rd = 1'($urandom);
                wr = rd;
            end else begin
                rd = (k < 5);
                wr = !rd;
            end
            do_req("rand", rd, wr, a, wd, md, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
